// File: rtl/dsp_cordic_pkg.sv
// Shared constants for the CORDIC-based polar/cartesian converters (frompolar, topolar).
// All angles and gains are signed Q16.16.
package dsp_cordic_pkg;

    localparam logic signed [31:0] PI_Q      = 32'sh0003_243F;
    localparam logic signed [31:0] HALF_PI_Q = 32'sh0001_9220;
    localparam logic signed [31:0] CORDIC_K  = 32'sh0000_9B75;

    // round(atan(2^-i) * 2^16)
    localparam logic signed [31:0] ATAN_LUT [16] = '{
        32'sh0000_C910, 32'sh0000_76B2, 32'sh0000_3EB7, 32'sh0000_1FD6,
        32'sh0000_0FFB, 32'sh0000_07FF, 32'sh0000_0400, 32'sh0000_0200,
        32'sh0000_0100, 32'sh0000_0080, 32'sh0000_0040, 32'sh0000_0020,
        32'sh0000_0010, 32'sh0000_0008, 32'sh0000_0004, 32'sh0000_0002
    };

endpackage

// File: rtl/cordic_rot_stage.sv
// One registered rotation-mode CORDIC micro-rotation with shift index SHIFT.
// Rotates (x, y) toward the residual angle z and carries the valid bit alongside.
module cordic_rot_stage
    import dsp_cordic_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int W     = 32,
    parameter int GW    = 2
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   vld,
    input  logic signed [W+GW-1:0] x,
    input  logic signed [W+GW-1:0] y,
    input  logic signed [W-1:0]    z,
    output logic                   vld_reg,
    output logic signed [W+GW-1:0] x_reg,
    output logic signed [W+GW-1:0] y_reg,
    output logic signed [W-1:0]    z_reg
);

    localparam int XW = W + GW;
    localparam logic signed [W-1:0] ATAN_STEP = W'(ATAN_LUT[SHIFT]);

    logic                 d_pos;
    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [XW-1:0] x_next;
    logic signed [XW-1:0] y_next;
    logic signed [W-1:0]  z_next;

    // Direction follows the sign of the remaining angle (z >= 0 rotates counter-clockwise).
    always_comb begin
        d_pos = ~z[W-1];
        x_sh  = x >>> SHIFT;
        y_sh  = y >>> SHIFT;
        if (d_pos) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - ATAN_STEP;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + ATAN_STEP;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            vld_reg <= 1'b0;
            x_reg   <= '0;
            y_reg   <= '0;
            z_reg   <= '0;
        end else begin
            vld_reg <= vld;
            x_reg   <= x_next;
            y_reg   <= y_next;
            z_reg   <= z_next;
        end
    end

endmodule

// File: rtl/frompolar.sv
// Polar-to-cartesian converter: fold stage, ITER pipelined CORDIC rotations, gain compensation.
// One sample per clock, latency ITER+2 clocks.
module frompolar
    import dsp_cordic_pkg::*;
#(
    parameter int W    = 32,
    parameter int ITER = 16,
    parameter int GW   = 2
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                i_vld,
    input  logic signed [W-1:0] i_mag,
    input  logic signed [W-1:0] i_phase,
    output logic                o_vld,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_y
);

    localparam int XW = W + GW;
    localparam int PW = XW + W;

    localparam logic signed [W-1:0]  PI_W      = W'(PI_Q);
    localparam logic signed [W-1:0]  HALF_PI_W = W'(HALF_PI_Q);
    localparam logic signed [PW-1:0] K_P       = PW'(CORDIC_K);
    localparam logic signed [PW-1:0] HALF_LSB  = PW'(32'sd32768);

    // Round half-up to Q16.16, then clamp to the W-bit signed range.
    function automatic logic signed [W-1:0] round_sat(input logic signed [PW-1:0] prod);
        logic signed [PW-1:0] rnd;
        logic signed [W-1:0]  res;
        rnd = (prod + HALF_LSB) >>> 16;
        if (rnd[PW-1:W-1] == {(PW-W+1){rnd[PW-1]}})
            res = rnd[W-1:0];
        else if (rnd[PW-1])
            res = {1'b1, {(W-1){1'b0}}};
        else
            res = {1'b0, {(W-1){1'b1}}};
        return res;
    endfunction

    logic signed [XW-1:0] mag_ext;
    logic signed [XW-1:0] x0_next;
    logic signed [W-1:0]  z0_next;

    logic                 vld0_reg;
    logic signed [XW-1:0] x0_reg;
    logic signed [W-1:0]  z0_reg;

    logic                 stage_vld [0:ITER];
    logic signed [XW-1:0] stage_x   [0:ITER];
    logic signed [XW-1:0] stage_y   [0:ITER];
    logic signed [W-1:0]  stage_z   [0:ITER];

    logic signed [PW-1:0] prod_x;
    logic signed [PW-1:0] prod_y;
    logic                 unused_z;

    // Fold phases beyond +/-pi/2 into the CORDIC convergence range by negating x.
    always_comb begin
        mag_ext = XW'(i_mag);
        x0_next = mag_ext;
        z0_next = i_phase;
        if (i_phase > HALF_PI_W) begin
            x0_next = -mag_ext;
            z0_next = i_phase - PI_W;
        end else if (i_phase < -HALF_PI_W) begin
            x0_next = -mag_ext;
            z0_next = i_phase + PI_W;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            vld0_reg <= 1'b0;
            x0_reg   <= '0;
            z0_reg   <= '0;
        end else begin
            vld0_reg <= i_vld;
            x0_reg   <= x0_next;
            z0_reg   <= z0_next;
        end
    end

    assign stage_vld[0] = vld0_reg;
    assign stage_x[0]   = x0_reg;
    assign stage_y[0]   = '0;
    assign stage_z[0]   = z0_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ITER; gi++) begin : g_stage
            cordic_rot_stage #(
                .SHIFT (gi),
                .W     (W),
                .GW    (GW)
            ) u_stage (
                .clk     (clk),
                .arstn   (arstn),
                .vld     (stage_vld[gi]),
                .x       (stage_x[gi]),
                .y       (stage_y[gi]),
                .z       (stage_z[gi]),
                .vld_reg (stage_vld[gi+1]),
                .x_reg   (stage_x[gi+1]),
                .y_reg   (stage_y[gi+1]),
                .z_reg   (stage_z[gi+1])
            );
        end
    endgenerate

    // Residual angle after the last rotation is not needed downstream.
    assign unused_z = ^stage_z[ITER];

    assign prod_x = PW'(stage_x[ITER]) * K_P;
    assign prod_y = PW'(stage_y[ITER]) * K_P;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            o_vld <= 1'b0;
            o_x   <= '0;
            o_y   <= '0;
        end else begin
            o_vld <= stage_vld[ITER];
            if (stage_vld[ITER]) begin
                o_x <= round_sat(prod_x);
                o_y <= round_sat(prod_y);
            end
        end
    end

endmodule

// File: tb/tb_frompolar.sv
// Self-checking bench for frompolar: directed cases, back-to-back bursts, random samples
// against a trigonometric reference, and asynchronous reset behaviour.
module tb_frompolar;

    localparam int LAT = 18;
    localparam int TOL = 8;
    localparam int ONE = 32'sh0001_0000;
    localparam int PI_Q      = 32'sh0003_243F;
    localparam int HALF_PI_Q = 32'sh0001_9220;

    logic        clk = 1'b0;
    logic        arstn;
    logic        i_vld;
    logic signed [31:0] i_mag;
    logic signed [31:0] i_phase;
    logic        o_vld;
    logic signed [31:0] o_x;
    logic signed [31:0] o_y;

    int cmp_cnt = 0;
    int err_cnt = 0;

    int bmag[$];
    int bph[$];
    int bex_x[$];
    int bex_y[$];
    int btol[$];

    always #5 clk = ~clk;

    frompolar dut (
        .clk     (clk),
        .arstn   (arstn),
        .i_vld   (i_vld),
        .i_mag   (i_mag),
        .i_phase (i_phase),
        .o_vld   (o_vld),
        .o_x     (o_x),
        .o_y     (o_y)
    );

    // Reference: mag*cos/sin of the quantized phase, rounded to the nearest Q16.16 LSB.
    function automatic int ref_coord(int mag, int ph, bit want_y);
        real m, p, v;
        m = $itor(mag) / 65536.0;
        p = $itor(ph) / 65536.0;
        v = m * (want_y ? $sin(p) : $cos(p)) * 65536.0;
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    task automatic check_val(string tag, longint obs, longint exp, longint tol);
        cmp_cnt++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d, expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic check_bit(string tag, logic obs, logic exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(int mag, int ph, int ex, int ey, int tol);
        bmag.push_back(mag);
        bph.push_back(ph);
        bex_x.push_back(ex);
        bex_y.push_back(ey);
        btol.push_back(tol);
    endtask

    task automatic push_model(int mag, int ph);
        push(mag, ph, ref_coord(mag, ph, 1'b0), ref_coord(mag, ph, 1'b1), TOL);
    endtask

    // Drives the queued samples on consecutive clocks (starting at a falling edge) and checks
    // o_vld every cycle: high exactly LAT cycles after each sample, in order.
    task automatic run_burst(string tag);
        int n;
        int j;
        n = bmag.size();
        for (int cyc = 1; cyc <= n + LAT + 1; cyc++) begin
            if (cyc <= n) begin
                i_vld   = 1'b1;
                i_mag   = bmag[cyc-1];
                i_phase = bph[cyc-1];
            end else begin
                i_vld   = 1'b0;
                i_mag   = $urandom;
                i_phase = $urandom;
            end
            @(negedge clk);
            j = cyc - LAT;
            check_bit($sformatf("%s_vld_c%0d", tag, cyc), o_vld, (j >= 0 && j < n));
            if (j >= 0 && j < n) begin
                $display("%s #%0d mag=%08h ph=%08h -> x=%08h y=%08h (ref %08h %08h)",
                         tag, j, bmag[j], bph[j], o_x, o_y, bex_x[j], bex_y[j]);
                check_val($sformatf("%s_x%0d", tag, j), o_x, bex_x[j], btol[j]);
                check_val($sformatf("%s_y%0d", tag, j), o_y, bex_y[j], btol[j]);
            end
        end
        bmag.delete();
        bph.delete();
        bex_x.delete();
        bex_y.delete();
        btol.delete();
    endtask

    task automatic drive_random(int n);
        for (int k = 0; k < n; k++) begin
            i_vld   = 1'b1;
            i_mag   = $urandom_range(0, 2 * ONE) - ONE;
            i_phase = $urandom_range(0, 2 * PI_Q) - PI_Q;
            @(negedge clk);
        end
        i_vld = 1'b0;
    endtask

    initial begin
        arstn   = 1'b0;
        i_vld   = 1'b0;
        i_mag   = '0;
        i_phase = '0;
        #1;
        check_bit("rst_vld", o_vld, 1'b0);
        check_val("rst_x", o_x, 0, 0);
        check_val("rst_y", o_y, 0, 0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        // Directed cases, each issued alone
        push(ONE, 0, ONE, 0, TOL);
        run_burst("t1_zero_phase");
        push(ONE, HALF_PI_Q, 0, ONE, TOL);
        run_burst("t2_half_pi");
        push(2 * ONE, -PI_Q, -2 * ONE, 0, TOL);
        run_burst("t3_minus_pi");
        push(32'sh0005_1959, 32'sh0001_5F98, ONE, 5 * ONE, TOL);
        run_burst("t4_roundtrip");
        push(0, 32'sh0000_8000, 0, 0, 0);
        run_burst("t_zero_mag");

        // Back-to-back quadrant walk
        push(ONE, 0, ONE, 0, TOL);
        push(ONE, HALF_PI_Q, 0, ONE, TOL);
        push(ONE, PI_Q, -ONE, 0, TOL);
        push(ONE, -HALF_PI_Q, 0, -ONE, TOL);
        run_burst("t5_burst");

        // Negative magnitude reflects through the origin
        push(-ONE, 32'sh0000_C910, ref_coord(-ONE, 32'sh0000_C910, 1'b0),
             ref_coord(-ONE, 32'sh0000_C910, 1'b1), TOL);
        run_burst("t_neg_mag");

        // Random samples back-to-back, every quadrant and both magnitude signs
        for (int k = 0; k < 24; k++)
            push_model($urandom_range(0, 2 * ONE) - ONE, $urandom_range(0, 2 * PI_Q) - PI_Q);
        run_burst("t_rand");

        // Reset 5 clocks after the first of three samples: those samples must never emerge
        drive_random(3);
        repeat (2) @(negedge clk);
        #2 arstn = 1'b0;
        #1 check_bit("t6_vld_at_rst", o_vld, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit($sformatf("t6_vld_in_rst%0d", k), o_vld, 1'b0);
        end
        arstn = 1'b1;
        push(ONE, HALF_PI_Q, 0, ONE, TOL);
        run_burst("t6_post_rst");

        // Reset while o_vld is high must clear it without waiting for a clock edge
        drive_random(LAT);
        check_bit("t7_vld_before_rst", o_vld, 1'b1);
        #2 arstn = 1'b0;
        #1 check_bit("t7_vld_async_clr", o_vld, 1'b0);
        @(negedge clk);
        arstn = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            check_bit($sformatf("t7_no_stale_c%0d", k), o_vld, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
